// File: rtl/hack_alu_pkg.sv
// Shared types for the Hack ALU arbiter: ALU control word, FSM states, default width.
package hack_alu_pkg;

  localparam int unsigned HACK_WIDTH = 16;

  // Field order matches the Hack control word {zx,nx,zy,ny,f,no}, zx in the MSB.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/hack_alu.sv
// Purely combinational Hack-style ALU: zero/negate each input, AND or ADD, negate output.
module hack_alu
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  alu_op_t          op_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o
);

  localparam int unsigned NumChunks = (WIDTH + 15) / 16;
  localparam int unsigned PadW      = NumChunks * 16;

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n;
  logic [WIDTH-1:0] sum, and_res, pre;
  logic [PadW-1:0]  x_pad, y_pad, and_pad;

  assign x_z = op_i.zx ? '0 : x_i;
  assign x_n = op_i.nx ? ~x_z : x_z;
  assign y_z = op_i.zy ? '0 : y_i;
  assign y_n = op_i.ny ? ~y_z : y_z;

  // AND path is tiled from 16-bit primitives; widths that are not a multiple of 16 are zero-padded.
  assign x_pad = PadW'(x_n);
  assign y_pad = PadW'(y_n);

  for (genvar c = 0; c < NumChunks; c++) begin : g_and
    hack_and16 u_and16 (
      .a_i   (x_pad[c*16 +: 16]),
      .b_i   (y_pad[c*16 +: 16]),
      .out_o (and_pad[c*16 +: 16])
    );
  end

  assign and_res = and_pad[WIDTH-1:0];
  assign sum     = x_n + y_n;
  assign pre     = op_i.f ? sum : and_res;
  assign out_o   = op_i.no ? ~pre : pre;
  assign zr_o    = (out_o == '0);
  assign ng_o    = out_o[WIDTH-1];

endmodule

// File: rtl/hack_and16.sv
// 16-bit bitwise AND primitive used as the ALU's AND path building block.
module hack_and16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] out_o
);

  assign out_o = a_i & b_i;

endmodule

// File: rtl/hack_alu_arbiter.sv
// Round-robin arbiter sharing one Hack ALU among NUM_REQ requesters; one request in flight,
// result held on a single valid/ready response channel.
module hack_alu_arbiter
  import hack_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = HACK_WIDTH,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_in,
  input  logic [NUM_REQ*6-1:0]     req_op_in,
  output logic                     rsp_valid_out,
  input  logic                     rsp_ready_in,
  output logic [ID_W-1:0]          rsp_id_out,
  output logic [WIDTH-1:0]         rsp_data_out,
  output logic                     rsp_zr_out,
  output logic                     rsp_ng_out
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  alu_op_t          cap_op_q, cap_op_d;
  logic [ID_W-1:0]  cap_id_q, cap_id_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zr_q, rsp_zr_d;
  logic             rsp_ng_q, rsp_ng_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W:0]      cand;
  logic [NUM_REQ-1:0] grant_vec;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zr, alu_ng;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid_in[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  hack_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .x_i   (cap_a_q),
    .y_i   (cap_b_q),
    .op_i  (cap_op_q),
    .out_o (alu_out),
    .zr_o  (alu_zr),
    .ng_o  (alu_ng)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cap_a_d     = cap_a_q;
    cap_b_d     = cap_b_q;
    cap_op_d    = cap_op_q;
    cap_id_d    = cap_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zr_d    = rsp_zr_q;
    rsp_ng_d    = rsp_ng_q;
    grant_vec   = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          grant_vec[grant_id] = 1'b1;
          cap_a_d  = req_a_in[grant_id*WIDTH +: WIDTH];
          cap_b_d  = req_b_in[grant_id*WIDTH +: WIDTH];
          cap_op_d = alu_op_t'(req_op_in[grant_id*6 +: 6]);
          cap_id_d = grant_id;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = cap_id_q;
        rsp_data_d  = alu_out;
        rsp_zr_d    = alu_zr;
        rsp_ng_d    = alu_ng;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_in) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (cap_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cap_id_q + ID_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_op_q    <= '0;
      cap_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_zr_q    <= 1'b0;
      rsp_ng_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cap_a_q     <= cap_a_d;
      cap_b_q     <= cap_b_d;
      cap_op_q    <= cap_op_d;
      cap_id_q    <= cap_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zr_q    <= rsp_zr_d;
      rsp_ng_q    <= rsp_ng_d;
    end
  end

  // Grant is combinational from valid, so mask it while reset is held to keep it low.
  assign req_ready_out = grant_vec & {NUM_REQ{rst_n_in}};
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_id_out    = rsp_id_q;
  assign rsp_data_out  = rsp_data_q;
  assign rsp_zr_out    = rsp_zr_q;
  assign rsp_ng_out    = rsp_ng_q;

endmodule

// File: tb/tb_hack_alu_arbiter.sv
// Scoreboard bench for hack_alu_arbiter: expected results queued at accept, checked at response.
module tb_hack_alu_arbiter;

  localparam int NR  = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           zr;
    logic           ng;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic [NR*6-1:0] req_op = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_data;
  logic            zr, ng;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hack_alu_arbiter #(
    .NUM_REQ (NR),
    .WIDTH   (W),
    .ID_W    (IDW)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_a_in      (req_a),
    .req_b_in      (req_b),
    .req_op_in     (req_op),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .rsp_id_out    (rsp_id),
    .rsp_data_out  (rsp_data),
    .rsp_zr_out    (zr),
    .rsp_ng_out    (ng)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [5:0] op);
    logic [W-1:0] x, y, o;
    x = a;
    y = b;
    if (op[5]) x = '0;
    if (op[4]) x = ~x;
    if (op[3]) y = '0;
    if (op[2]) y = ~y;
    o = op[1] ? (x + y) : (x & y);
    if (op[0]) o = ~o;
    return o;
  endfunction

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] op);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_op[i*6 +: 6] = op;
    req_valid[i]     = 1'b1;
  endtask

  task automatic load_all();
    set_req(0, 16'h1234, 16'h0F0F, 6'b000010);
    set_req(1, 16'hA5A5, 16'h5AFF, 6'b000000);
    set_req(2, 16'h0007, 16'h0009, 6'b010011);
    set_req(3, 16'h0100, 16'h0001, 6'b000111);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
    next();
  endtask

  // Waits (bounded) for a grant, queues its expected response, returns at the next cycle.
  task automatic accept(input bit drop, output int gid, output int at);
    int   k;
    bit   found;
    rsp_t e;
    k = 0;
    found = 1'b0;
    gid = -1;
    at = -1;
    while (!found && k < 12) begin
      #1;
      if (req_ready !== '0) begin
        found = 1'b1;
        at = cyc;
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i] === 1'b1) gid = i;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (found && gid >= 0) begin
      e.id   = IDW'(gid);
      e.data = model(req_a[gid*W +: W], req_b[gid*W +: W], req_op[gid*6 +: 6]);
      e.zr   = (e.data == '0);
      e.ng   = e.data[W-1];
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (drop) req_valid[gid] = 1'b0;
      next();
    end
  endtask

  task automatic get_rsp(output rsp_t got, output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    got = '0;
    while (!ok && k < 12) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        got = {rsp_id, rsp_data, zr, ng};
      end else begin
        next();
        k++;
      end
    end
  endtask

  task automatic pop_exp(output rsp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    next();
    next();
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, zr, ng} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {req_ready, rsp_valid, rsp_id, rsp_data, zr, ng});
    end
    req_valid = '0;
    rst_n = 1'b1;
    next();
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_grant ready=%b rsp_valid=%b required 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single();
    int g, t;
    rsp_t got, e;
    bit ok;
    rsp_ready = 1'b1;
    set_req(1, 16'h00F0, 16'h0FF0, 6'b000000);
    accept(1'b1, g, t);
    checks++;
    if (g != 1) begin errors++; $display("FAIL single_grant got=%0d required=1", g); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b required=0", rsp_valid); end
    next();
    checks++;
    if (rsp_valid !== 1'b1 || cyc != t + 2) begin
      errors++;
      $display("FAIL single_latency valid=%b cycles=%0d required=2", rsp_valid, cyc - t);
    end
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (!ok || got !== e || got.data !== 16'h00F0) begin
      errors++;
      $display("FAIL single_rsp got=%h required=%h ok=%0d", got, e, ok);
    end
    next();
  endtask

  task automatic test_flags();
    int g, t;
    rsp_t got, e;
    bit ok;
    set_req(0, 16'h7FFF, 16'h0001, 6'b000010);
    accept(1'b1, g, t);
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (g != 0 || !ok || got !== e || got.data !== 16'h8000 || got.ng !== 1'b1) begin
      errors++;
      $display("FAIL add_overflow grant=%0d got=%h required=%h", g, got, e);
    end
    next();
    set_req(0, 16'hBEEF, 16'h1234, 6'b101010);
    accept(1'b1, g, t);
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (g != 0 || !ok || got !== e || got.zr !== 1'b1) begin
      errors++;
      $display("FAIL const_zero grant=%0d got=%h required=%h", g, got, e);
    end
    next();
  endtask

  task automatic test_round_robin();
    int g, t, prev;
    rsp_t got, e;
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    load_all();
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      accept(1'b0, g, t);
      checks++;
      if (g != n % NR || (n > 0 && t - prev != 3)) begin
        errors++;
        $display("FAIL rr_order step=%0d grant=%0d required=%0d spacing=%0d", n, g, n % NR, t - prev);
      end
      prev = t;
      get_rsp(got, ok);
      pop_exp(e);
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL rr_rsp step=%0d got=%h required=%h", n, got, e);
      end
      next();
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int g, t, tc;
    rsp_t got, e, snap;
    bit ok;
    // rr_ptr is 1 after the round-robin run.
    set_req(1, 16'hFFFF, 16'h0001, 6'b000010);
    set_req(3, 16'h00FF, 16'h0F00, 6'b010101);
    rsp_ready = 1'b0;
    accept(1'b1, g, t);
    get_rsp(got, ok);
    snap = got;
    pop_exp(e);
    checks++;
    if (g != 1 || !ok || got !== e) begin
      errors++;
      $display("FAIL bp_rsp grant=%0d got=%h required=%h", g, got, e);
    end
    for (int n = 0; n < 5; n++) begin
      next();
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_data, zr, ng} !== snap || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got=%h required=%h ready=%b", n, {rsp_id, rsp_data, zr, ng},
                 snap, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tc = cyc;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_consume_grant got=%b required=0", req_ready); end
    next();
    accept(1'b1, g, t);
    checks++;
    if (g != 3 || t != tc + 1) begin
      errors++;
      $display("FAIL bp_next_grant grant=%0d required=3 delay=%0d required=1", g, t - tc);
    end
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL bp_rsp2 got=%h required=%h", got, e); end
    next();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int g, t;
    rsp_t got, e;
    bit ok;
    rsp_ready = 1'b1;
    set_req(2, 16'h0003, 16'h0004, 6'b000010);
    accept(1'b1, g, t);
    get_rsp(got, ok);
    pop_exp(e);
    next();
    // rr_ptr is now 3; reset while requester 3's operation is in EXEC.
    set_req(3, 16'h1111, 16'h2222, 6'b000010);
    accept(1'b0, g, t);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, zr, ng} !== '0) begin
      errors++;
      $display("FAIL reset_exec got=%h required=0", {req_ready, rsp_valid, rsp_id, rsp_data, zr, ng});
    end
    sb.delete();
    load_all();
    next();
    rst_n = 1'b1;
    accept(1'b1, g, t);
    checks++;
    if (g != 0) begin errors++; $display("FAIL reset_exec_grant got=%0d required=0", g); end
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL reset_exec_rsp got=%h required=%h", got, e); end
    next();
    req_valid = '0;
    // Reset while a response is held in RESP.
    set_req(2, 16'h00AA, 16'h0055, 6'b000010);
    rsp_ready = 1'b0;
    accept(1'b1, g, t);
    get_rsp(got, ok);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {req_ready, rsp_valid, rsp_id, rsp_data, zr, ng} !== '0) begin
      errors++;
      $display("FAIL reset_resp got=%h required=0 ok=%0d", {req_ready, rsp_valid, rsp_id, rsp_data, zr, ng}, ok);
    end
    sb.delete();
    load_all();
    rsp_ready = 1'b1;
    next();
    rst_n = 1'b1;
    accept(1'b1, g, t);
    checks++;
    if (g != 0) begin errors++; $display("FAIL reset_resp_grant got=%0d required=0", g); end
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL reset_resp_rsp got=%h required=%h", got, e); end
    next();
    req_valid = '0;
  endtask

  task automatic test_rr_ptr3();
    int g, t;
    rsp_t got, e;
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 16'h0010, 16'h0020, 6'b000010);
    accept(1'b1, g, t);
    get_rsp(got, ok);
    pop_exp(e);
    next();
    set_req(2, 16'h4000, 16'h4000, 6'b000010);
    set_req(3, 16'h0000, 16'h1357, 6'b001101);
    accept(1'b1, g, t);
    checks++;
    if (g != 3) begin errors++; $display("FAIL ptr3_first grant=%0d required=3", g); end
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (!ok || got !== e || got.data !== 16'hFFFF || got.ng !== 1'b1) begin
      errors++;
      $display("FAIL ptr3_not_x got=%h required=%h", got, e);
    end
    next();
    accept(1'b1, g, t);
    checks++;
    if (g != 2) begin errors++; $display("FAIL ptr3_second grant=%0d required=2", g); end
    get_rsp(got, ok);
    pop_exp(e);
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL ptr3_rsp2 got=%h required=%h", got, e); end
    next();
    req_valid = '0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_flags();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_rr_ptr3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_alu_arbiter.md
Name: hack_alu_arbiter

Overview:
Shares one Hack-style 16-bit ALU (zx/nx/zy/ny/f/no control, AND or ADD core) between NUM_REQ requesters using round-robin arbitration and a valid/ready handshake.
- Each accepted request is captured, executed in one registered cycle, then held on a single response channel until consumed.
- Sits between the CPU-side requesters (fetch/decode, DMA, test port) and the shared combinational ALU datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
WIDTH, 16, operand and result width.
ID_W, $clog2(NUM_REQ), requester index width.

Ports:
clk_in  input  1  clock, rising edge.
rst_n_in  input  1  asynchronous active-low reset.
req_valid_in  input  NUM_REQ  per-requester request valid.
req_ready_out  output  NUM_REQ  one-hot accept; high only for the granted requester in its accept cycle.
req_a_in  input  NUM_REQ*WIDTH  x operands, requester i at [i*WIDTH +: WIDTH].
req_b_in  input  NUM_REQ*WIDTH  y operands, same packing.
req_op_in  input  NUM_REQ*6  ALU control {zx,nx,zy,ny,f,no}, requester i at [i*6 +: 6].
rsp_valid_out  output  1  response valid.
rsp_ready_in  input  1  response consumer ready.
rsp_id_out  output  ID_W  index of the requester that issued the result.
rsp_data_out  output  WIDTH  ALU result.
rsp_zr_out  output  1  result == 0.
rsp_ng_out  output  1  result[WIDTH-1].

Behaviour:
- Reset values: req_ready_out=0, rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, rsp_zr_out=0, rsp_ng_out=0, state=IDLE, rr_ptr=0. Reset is asynchronous and active-low. Asserting it mid-operation drops any captured request and any pending response; nothing is replayed.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Combinationally selects the first valid requester, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - If any request is valid, asserts req_ready_out[g] for that cycle only. A transfer occurs when valid and ready are both high.
  - Captures a, b, op and g into registers and moves to EXEC. With no valid request, stays in IDLE.
- EXEC:
  - The ALU sub-module evaluates the captured operands.
  - Registers data, zr, ng and id, sets rsp_valid_out=1 and moves to RESP.
- RESP:
  - Outputs are held stable while rsp_valid_out=1 and rsp_ready_in=0.
  - On rsp_valid_out and rsp_ready_in both high: rsp_valid_out=0, rr_ptr=(g+1) mod NUM_REQ, state returns to IDLE.
  - No new grant is issued in the same cycle the response is consumed.
- Latency: accept cycle T, rsp_valid_out high from T+2. Minimum spacing between accepts is 3 cycles, assuming rsp_ready_in is held high.
- ALU function, applied in this order:
  - x' = zx ? 0 : a; x'' = nx ? ~x' : x'.
  - The same two steps produce y'' from b, zy and ny.
  - o = f ? (x''+y'') mod 2^WIDTH : x'' & y''. The carry out is discarded.
  - out = no ? ~o : o.
- Requesters must hold valid, a, b and op stable until accepted. The arbiter never grants a requester whose valid is low.
- Fairness: a requester that stays valid is granted within NUM_REQ grants.
- rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Package hack_alu_pkg holds:
  - The alu_op_t packed struct {zx,nx,zy,ny,f,no}.
  - The state enum {IDLE,EXEC,RESP}.
  - The constant HACK_WIDTH=16.
- Sub-module hack_alu: purely combinational WIDTH-bit ALU. Inputs are x, y and an alu_op_t; outputs are out, zr and ng.
- The AND path is built from the team's existing 16-bit AND primitive.
- Arbitration, capture registers and the FSM live in hack_alu_arbiter.

Test Plan:
1. Single request, requester 1: a=0x00F0, b=0x0FF0, op=000000 (AND). Required: rsp_data=0x00F0, id=1, zr=0, ng=0, rsp_valid exactly 2 cycles after accept.
2. Requester 0: a=0x7FFF, b=0x0001, op=000010 (ADD). Required: rsp_data=0x8000, ng=1. Then op=101010 (constant 0). Required: rsp_data=0x0000, zr=1.
3. All 4 requesters held valid, rsp_ready_in=1. Required: grant order 0,1,2,3,0, with rr_ptr wrapping after 3.
4. rsp_ready_in held low for 5 cycles in RESP. Required: response outputs stable, no req_ready_out pulses. Releasing ready returns to IDLE, and the next grant comes no earlier than the following cycle.
5. Reset asserted in EXEC and, separately, in RESP. Required: all outputs 0 asynchronously, and the first grant after release goes to requester 0.
6. Requesters 2 and 3 valid, rr_ptr=3. Required: 3 is granted first, then 2. op=001101 (!x) with a=0x0000 gives 0xFFFF, ng=1.
